// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 8;
    localparam int REG_W   = 5;

    typedef enum logic [STATE_W-1:0] {
        RUN     = 2'd0,
        MULTI   = 2'd1,
        RETWAIT = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction
endpackage

// File: rtl/pipe_load_use_det.sv
// pipe_load_use_det: flags an ID instruction that reads the register a load in EX is about to write.
module pipe_load_use_det
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_load,
    input  logic             id_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             load_use
);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_load && id_valid && (ex_rd != '0) &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for branches, load-use, multi-cycle ALU ops and returns.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT   = 8,
    parameter int RET_DRAIN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               id_ret,
    input  logic [REG_W-1:0]   ex_rd,
    input  logic               ex_load,
    input  logic               ex_multi,
    input  logic               ex_br_taken,
    output logic               pc_we,
    output logic               if_id_we,
    output logic               id_ex_we,
    output logic               if_id_flush,
    output logic               id_ex_bubble,
    output logic               pc_sel_ret,
    output logic               busy,
    output logic [STATE_W-1:0] state
);
    state_t           st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             load_use;

    pipe_load_use_det u_det (
        .ex_load    (ex_load),
        .id_valid   (id_valid),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .load_use   (load_use)
    );

    always_comb begin
        st_nx        = st;
        cnt_nx       = cnt;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pc_sel_ret   = 1'b0;
        case (st)
            RUN: begin
                if (ex_br_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (ex_multi) begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                    id_ex_we = 1'b0;
                    cnt_nx   = CNT_W'(DIV_LAT - 2);
                    st_nx    = MULTI;
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_ret && id_valid) begin
                    cnt_nx = CNT_W'(RET_DRAIN - 1);
                    st_nx  = RETWAIT;
                end
            end
            MULTI: begin
                if (cnt != '0) begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                    id_ex_we = 1'b0;
                    cnt_nx   = sat_dec(cnt);
                end else begin
                    st_nx = RUN;
                end
            end
            RETWAIT: begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
                if (cnt != '0) begin
                    cnt_nx = sat_dec(cnt);
                end else begin
                    pc_we      = 1'b1;
                    pc_sel_ret = 1'b1;
                    st_nx      = RUN;
                end
            end
            default: begin
                pc_we    = 1'b0;
                if_id_we = 1'b0;
                id_ex_we = 1'b0;
                cnt_nx   = '0;
                st_nx    = RUN;
            end
        endcase
        // reset overrides combinationally so the pipeline is quiesced without waiting for a clock
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pc_sel_ret   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= RUN;
            cnt <= '0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

    assign busy  = (st != RUN);
    assign state = st;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a cycle-occupancy model.
module tb_pipe_hazard_ctrl;
    localparam int DIV_LAT   = 8;
    localparam int RET_DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_ret = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       ex_load = 1'b0, ex_multi = 1'b0, ex_br_taken = 1'b0;
    logic       pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, pc_sel_ret, busy;
    logic [1:0] state;
    logic [5:0] outs;

    int checks = 0;
    int errors = 0;

    // model: mode 0=running, 1=multi-cycle op occupying EX, 2=return drain; left = cycles still to go
    int mode = 0;
    int left = 0;

    localparam logic [5:0] O_RUN   = 6'b111000;
    localparam logic [5:0] O_STALL = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b001010;
    localparam logic [5:0] O_BR    = 6'b111110;
    localparam logic [5:0] O_RST   = 6'b000110;
    localparam logic [5:0] O_RETW  = 6'b011100;
    localparam logic [5:0] O_RETL  = 6'b111101;

    pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .RET_DRAIN(RET_DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ret(id_ret), .ex_rd(ex_rd),
        .ex_load(ex_load), .ex_multi(ex_multi), .ex_br_taken(ex_br_taken), .pc_we(pc_we),
        .if_id_we(if_id_we), .id_ex_we(id_ex_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pc_sel_ret(pc_sel_ret), .busy(busy), .state(state)
    );

    assign outs = {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, pc_sel_ret};

    always #5 clk = ~clk;

    function automatic logic lu_now();
        return ex_load && id_valid && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    always @(posedge clk)
        if (rst_n && busy)
            assert (!(ex_br_taken || ex_multi || lu_now() || (id_ret && id_valid)))
                else $error("protocol violation: event while busy");

    function automatic logic [5:0] model_out();
        if (mode == 1) return (left > 1) ? O_STALL : O_RUN;
        if (mode == 2) return (left == 1) ? O_RETL : O_RETW;
        if (ex_br_taken) return O_BR;
        if (ex_multi) return O_STALL;
        if (lu_now()) return O_LU;
        return O_RUN;
    endfunction

    task automatic model_step();
        if (mode == 1) begin
            if (left > 1) left--; else mode = 0;
        end else if (mode == 2) begin
            if (left == 1) mode = 0; else left--;
        end else if (!ex_br_taken && ex_multi) begin
            mode = 1; left = DIV_LAT - 1;
        end else if (!ex_br_taken && !lu_now() && id_ret && id_valid) begin
            mode = 2; left = RET_DRAIN;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {id_valid, id_use_rs1, id_use_rs2, id_ret, ex_load, ex_multi, ex_br_taken} = '0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (outs !== O_RST || state !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold outs=%b state=%0d busy=%b expected outs=%b state=0 busy=0", outs, state, busy, O_RST);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release outs=%b state=%0d expected outs=%b state=0", outs, state, O_RUN);
        end
    endtask

    task automatic test_load_use();
        clear_in();
        ex_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_valid = 1;
        #1;
        checks++;
        if (outs !== O_LU || state !== 2'd0) begin
            errors++;
            $display("FAIL load_use_rs1 outs=%b state=%0d expected outs=%b state=0", outs, state, O_LU);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'd0) begin
            errors++;
            $display("FAIL load_use_one_cycle outs=%b state=%0d expected outs=%b state=0", outs, state, O_RUN);
        end
        ex_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; id_valid = 1;
        #1;
        checks++;
        if (outs !== O_RUN) begin
            errors++;
            $display("FAIL load_use_x0 outs=%b expected %b", outs, O_RUN);
        end
        clear_in();
        ex_load = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_valid = 1;
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++;
            $display("FAIL load_use_rs2 outs=%b expected %b", outs, O_LU);
        end
        id_use_rs2 = 0;
        #1;
        checks++;
        if (outs !== O_RUN) begin
            errors++;
            $display("FAIL load_use_unused_src outs=%b expected %b", outs, O_RUN);
        end
        tick();
        clear_in();
    endtask

    task automatic test_multi();
        int stalls = 0;
        clear_in();
        ex_multi = 1;
        #1;
        if (outs === O_STALL && state === 2'd0) stalls++;
        tick();
        ex_multi = 0;
        for (int i = 0; i < DIV_LAT + 4 && state !== 2'd0; i++) begin
            #1;
            if (outs === O_STALL) stalls++;
            else begin
                checks++;
                if (outs !== O_RUN || state !== 2'd1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL multi_release outs=%b state=%0d busy=%b expected outs=%b state=1 busy=1", outs, state, busy, O_RUN);
                end
            end
            tick();
        end
        checks++;
        if (stalls != DIV_LAT - 1) begin
            errors++;
            $display("FAIL multi_stalls got=%0d expected=%0d", stalls, DIV_LAT - 1);
        end
        #1;
        checks++;
        if (state !== 2'd0 || outs !== O_RUN) begin
            errors++;
            $display("FAIL multi_back_to_run state=%0d outs=%b expected state=0 outs=%b", state, outs, O_RUN);
        end
    endtask

    task automatic test_ret();
        clear_in();
        id_ret = 1; id_valid = 1;
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'd0) begin
            errors++;
            $display("FAIL ret_issue outs=%b state=%0d expected outs=%b state=0", outs, state, O_RUN);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (outs !== O_RETW || state !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ret_wait1 outs=%b state=%0d busy=%b expected outs=%b state=2 busy=1", outs, state, busy, O_RETW);
        end
        tick();
        checks++;
        if (outs !== O_RETL || state !== 2'd2) begin
            errors++;
            $display("FAIL ret_wait2 outs=%b state=%0d expected outs=%b state=2", outs, state, O_RETL);
        end
        tick();
        checks++;
        if (outs !== O_RUN || state !== 2'd0) begin
            errors++;
            $display("FAIL ret_back_to_run outs=%b state=%0d expected outs=%b state=0", outs, state, O_RUN);
        end
    endtask

    task automatic test_priority();
        clear_in();
        ex_br_taken = 1; ex_multi = 1; ex_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        id_valid = 1; id_ret = 1;
        #1;
        checks++;
        if (outs !== O_BR) begin
            errors++;
            $display("FAIL priority_outs outs=%b expected %b", outs, O_BR);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (state !== 2'd0 || outs !== O_RUN) begin
            errors++;
            $display("FAIL priority_state state=%0d outs=%b expected state=0 outs=%b", state, outs, O_RUN);
        end
        ex_multi = 1; ex_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; id_valid = 1;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL priority_multi_over_lu outs=%b expected %b", outs, O_STALL);
        end
        ex_multi = 0; id_ret = 1;
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++;
            $display("FAIL priority_lu_over_ret outs=%b expected %b", outs, O_LU);
        end
        tick();
        clear_in();
        #1;
    endtask

    task automatic test_reset_mid_op();
        clear_in();
        ex_multi = 1;
        tick();
        ex_multi = 0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || outs !== O_RST || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_multi state=%0d outs=%b busy=%b expected state=0 outs=%b busy=0", state, outs, busy, O_RST);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || outs !== O_RUN) begin
            errors++;
            $display("FAIL reset_mid_release state=%0d outs=%b expected state=0 outs=%b", state, outs, O_RUN);
        end
        tick();
        checks++;
        if (state !== 2'd0 || outs !== O_RUN) begin
            errors++;
            $display("FAIL reset_mid_after state=%0d outs=%b expected state=0 outs=%b", state, outs, O_RUN);
        end
    endtask

    task automatic test_random();
        logic [5:0] exp;
        mode = 0;
        left = 0;
        for (int i = 0; i < 400; i++) begin
            clear_in();
            if (mode == 0) begin
                ex_br_taken = ($urandom_range(7) == 0);
                ex_multi    = ($urandom_range(15) == 0);
                id_ret      = ($urandom_range(5) == 0);
                ex_load     = 1'($urandom_range(1));
            end
            id_valid   = ($urandom_range(3) != 0);
            ex_rd      = 5'($urandom_range(3));
            id_rs1     = 5'($urandom_range(3));
            id_rs2     = 5'($urandom_range(3));
            id_use_rs1 = 1'($urandom_range(1));
            id_use_rs2 = 1'($urandom_range(1));
            #1;
            exp = model_out();
            checks++;
            if (outs !== exp || state !== 2'(mode) || busy !== (mode != 0)) begin
                errors++;
                $display("FAIL random_cycle%0d outs=%b state=%0d busy=%b expected outs=%b state=%0d busy=%0d",
                         i, outs, state, busy, exp, mode, mode != 0);
            end
            model_step();
            tick();
        end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multi();
        test_ret();
        test_priority();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
